// File: rtl/move_tx_queue.sv
// Queues outgoing moves and hands them to the UART tx one frame at a time,
// holding tx_data through frame + idle gap so the peer re-syncs between packets.
module move_tx_queue #(
    parameter int PKT_LEN    = 8,
    parameter int DIVISOR    = 6771,
    parameter int GAP_CYCLES = 65_000,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     move_valid,
    input  logic [PKT_LEN-1:0]       move_in,
    output logic                     tx_trigger,
    output logic [PKT_LEN-1:0]       tx_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int T  = DIVISOR * (PKT_LEN + 2) + GAP_CYCLES;
    localparam int TW = $clog2(T + 1);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [PKT_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic               full, empty, pop, push;

    always_comb begin
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
        pop   = (state == IDLE) && !empty;
        // A pop in the same cycle frees a slot, so a full queue still accepts the write.
        push  = move_valid && (!full || pop);
        busy  = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: if (!empty) state_nxt = SEND;
            SEND: begin
                state_nxt = HOLD;
                timer_nxt = TW'(T - 2);
            end
            HOLD: begin
                // IDLE + SEND + (T-2) HOLD cycles give exactly T cycles per packet.
                timer_nxt = timer - 1'b1;
                if (timer <= TW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            timer      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            tx_trigger <= 1'b0;
            tx_data    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            tx_trigger <= (state == SEND);
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (move_valid && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= move_in;
    end

endmodule

// File: tb/tb_move_tx_queue.sv
// Randomized + directed bench for move_tx_queue against a queue/timestamp model.
module tb_move_tx_queue;

    localparam int PKT_LEN = 8, DIVISOR = 4, GAP_CYCLES = 3, DEPTH = 4;
    localparam int T = DIVISOR * (PKT_LEN + 2) + GAP_CYCLES;

    logic         clk_in = 1'b0;
    logic         rst_in, move_valid;
    logic [7:0]   move_in;
    logic         tx_trigger, busy, overflow;
    logic [7:0]   tx_data;
    logic [2:0]   count;

    move_tx_queue #(.PKT_LEN(PKT_LEN), .DIVISOR(DIVISOR), .GAP_CYCLES(GAP_CYCLES), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .move_valid(move_valid), .move_in(move_in),
        .tx_trigger(tx_trigger), .tx_data(tx_data), .count(count), .busy(busy), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a packet may start once T cycles have elapsed since the previous start.
    int         cyc = 0;
    bit         m_popped = 0;
    int         m_last = 0;
    logic [7:0] m_q[$];
    bit         m_ovf = 0;
    logic [7:0] m_txd = 0;
    int         trig_e[$];
    logic [7:0] trig_d[$];

    task automatic tick();
        bit pop, full;
        @(posedge clk_in);
        cyc++;
        if (rst_in) begin
            m_q.delete(); m_ovf = 0; m_txd = 0; m_popped = 0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && (!m_popped || cyc - m_last >= T);
            if (pop) begin
                m_txd = m_q.pop_front(); m_last = cyc; m_popped = 1;
            end
            if (move_valid) begin
                if (!full || pop) m_q.push_back(move_in);
                else m_ovf = 1;
            end
        end
        #1;
        chk("count", count, m_q.size());
        chk("tx_trigger", tx_trigger, m_popped && cyc == m_last + 1);
        chk("busy", busy, m_popped && cyc - m_last <= T - 2);
        chk("tx_data", tx_data, m_txd);
        chk("overflow", overflow, m_ovf);
        if (tx_trigger) begin
            trig_e.push_back(cyc); trig_d.push_back(tx_data);
        end
    endtask

    task automatic push(input logic [7:0] v);
        move_valid = 1'b1; move_in = v;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_trigs(input int n, input int bound);
        for (int i = 0; i < bound && trig_e.size() < n; i++) tick();
        chk("trigger_count", trig_e.size(), n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * T && busy; i++) tick();
        chk("wait_idle", busy, 0);
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b1; idle(n); rst_in = 1'b0;
    endtask

    initial begin
        int n;
        rst_in = 1'b1; move_valid = 1'b0; move_in = 8'h00;

        // 1: reset
        idle(3);
        chk("rst_trig", tx_trigger, 0); chk("rst_busy", busy, 0);
        chk("rst_count", count, 0); chk("rst_ovf", overflow, 0); chk("rst_data", tx_data, 0);
        rst_in = 1'b0;
        idle(2);

        // 2: single move latency
        push(8'h5A);
        chk("s2_count", count, 1);
        tick(); chk("s2_early_trig", tx_trigger, 0);
        tick(); chk("s2_trig", tx_trigger, 1); chk("s2_data", tx_data, 8'h5A); chk("s2_busy", busy, 1);
        n = 0;
        while (busy && n < T) begin tick(); n++; end
        chk("s2_busy_fall", busy, 0);
        idle(5);

        // 3: burst of three
        trig_e.delete(); trig_d.delete();
        push(8'h11); push(8'h22); push(8'h33);
        wait_trigs(3, 300);
        if (trig_e.size() == 3) begin
            chk("s3_gap1", trig_e[1] - trig_e[0], T);
            chk("s3_gap2", trig_e[2] - trig_e[1], T);
            chk("s3_d0", trig_d[0], 8'h11); chk("s3_d1", trig_d[1], 8'h22); chk("s3_d2", trig_d[2], 8'h33);
        end
        wait_idle();

        // 4: overflow, six back-to-back pushes
        trig_e.delete(); trig_d.delete();
        for (int i = 0; i < 6; i++) push(8'hA1 + 8'(i));
        chk("s4_ovf", overflow, 1); chk("s4_count", count, 4);
        wait_trigs(5, 400);
        for (int i = 0; i < 5 && i < trig_d.size(); i++) chk("s4_order", trig_d[i], 8'hA1 + 8'(i));
        wait_idle();
        do_reset(1);

        // 5: push on the pop cycle while full
        trig_e.delete(); trig_d.delete();
        for (int i = 0; i < 5; i++) push(8'hB1 + 8'(i));
        idle(T - 4);
        chk("s5_full", count, 4);
        push(8'hB6);
        chk("s5_count", count, 4); chk("s5_ovf", overflow, 0);
        wait_trigs(6, 500);
        for (int i = 0; i < 6 && i < trig_d.size(); i++) chk("s5_order", trig_d[i], 8'hB1 + 8'(i));
        wait_idle();

        // 6: reset mid-HOLD with two queued
        push(8'hC1); push(8'hC2); push(8'hC3);
        idle(10);
        chk("s6_pre_count", count, 2);
        do_reset(1);
        chk("s6_busy", busy, 0); chk("s6_count", count, 0);
        trig_e.delete(); trig_d.delete();
        idle(100);
        chk("s6_no_trig", trig_e.size(), 0);
        push(8'hC4); tick(); tick();
        chk("s6_trig", tx_trigger, 1); chk("s6_data", tx_data, 8'hC4);
        wait_idle();

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_in     = ($urandom_range(0, 499) == 0);
            move_valid = ($urandom_range(0, 7) == 0);
            move_in    = 8'($urandom);
            tick();
        end
        rst_in = 1'b0; move_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
